pe_op_sequencer: RTL and testbench

- Per-PE command sequencer for the double-precision PE datapath (ADD/ACC/MUL/MACC/NOP).
- Accepts vector commands (op, length, header flag) over a valid/ready port and drives the PE opcode.
- Gates the operand stream valid/last into the PE and marks the VLEN header beat for sparse-accumulate (en_ITR_sp).
- Holds the opcode stable until the PE pipeline drains and the final result beat (t_last) is observed, so back-to-back commands never see a mid-stream op change.

---
 rtl/pe_op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_pe_op_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_op_sequencer.sv
// Per-PE command sequencer for the double-precision PE datapath.
// Accepts one vector command at a time, gates the operand stream into the PE,
// regenerates t_last from the beat count, marks the sparse-ACC header beat and
// holds the PE opcode until the pipeline has drained the final result.
// LATENCY must be even and at least 2.

module pe_op_sequencer #(
    parameter int LATENCY = 16,
    parameter int CNT_W   = 16,
    parameter int SLACK   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_vlen,
    input  logic             cmd_hdr,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [2:0]       pe_op,
    output logic             pe_valid,
    output logic             pe_last,
    output logic             pe_en_itr_sp,
    input  logic             pe_out_valid,
    input  logic             pe_out_last,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             err_timeout
);

    localparam logic [2:0] OP_NOP = 3'b100;

    // The drain counter gives up once it has spent LATENCY+SLACK cycles waiting.
    localparam int                TMO_CYCLES = LATENCY + SLACK;
    localparam int                DRN_W      = $clog2(TMO_CYCLES + 1);
    localparam logic [DRN_W-1:0]  DRN_LIMIT  = DRN_W'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [2:0]       op_reg;
    logic [CNT_W-1:0] vlen_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [DRN_W-1:0] drain_cnt_reg;
    logic             done_reg;
    logic             err_len_reg;
    logic             err_timeout_reg;

    logic             accept;
    logic             beat;
    logic [CNT_W-1:0] vlen_m1;
    logic             last_beat;
    logic             out_last;
    logic             drain_expired;
    logic             zero_len_cmd;

    assign accept        = cmd_valid && cmd_ready;
    assign beat          = s_valid && s_ready;
    // vlen_reg is never zero while STREAM is active, so the wrap at zero is harmless.
    assign vlen_m1       = vlen_reg - CNT_W'(1);
    assign last_beat     = (cnt_reg == vlen_m1);
    assign out_last      = pe_out_valid && pe_out_last;
    assign drain_expired = (drain_cnt_reg == DRN_LIMIT);
    assign zero_len_cmd  = (cmd_vlen == '0) && !cmd_hdr;

    assign pe_op       = op_reg;
    assign done        = done_reg;
    assign err_len     = err_len_reg;
    assign err_timeout = err_timeout_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && !zero_len_cmd) begin
                    state_next = cmd_hdr ? ST_HDR : ST_STREAM;
                end
            end
            ST_HDR: begin
                if (beat) begin
                    state_next = (vlen_reg == '0) ? ST_DRAIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (beat && last_beat) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_last || drain_expired) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and stream outputs; everything is forced low while in reset.
    always_comb begin
        cmd_ready    = 1'b0;
        s_ready      = 1'b0;
        pe_valid     = 1'b0;
        pe_last      = 1'b0;
        pe_en_itr_sp = 1'b0;
        busy         = 1'b0;
        if (rst_n) begin
            busy = (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                end
                ST_HDR: begin
                    s_ready      = 1'b1;
                    pe_valid     = s_valid;
                    pe_en_itr_sp = 1'b1;
                end
                ST_STREAM: begin
                    s_ready  = 1'b1;
                    pe_valid = s_valid;
                    pe_last  = s_valid && last_beat;
                end
                default: begin
                    // DRAIN: operand port closed, opcode held.
                end
            endcase
        end
    end

    // Command latch, beat/drain counters, done pulse and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_reg          <= OP_NOP;
            vlen_reg        <= '0;
            cnt_reg         <= '0;
            drain_cnt_reg   <= '0;
            done_reg        <= 1'b0;
            err_len_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg        <= cmd_op;
                        vlen_reg      <= cmd_vlen;
                        cnt_reg       <= '0;
                        drain_cnt_reg <= '0;
                        if (zero_len_cmd) begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    cnt_reg       <= '0;
                    drain_cnt_reg <= '0;
                end
                ST_STREAM: begin
                    if (beat) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        // Upstream t_last must coincide exactly with the counted final beat.
                        if (s_last != last_beat) begin
                            err_len_reg <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_reg <= drain_cnt_reg + DRN_W'(1);
                    if (out_last) begin
                        done_reg <= 1'b1;
                    end else if (drain_expired) begin
                        done_reg        <= 1'b1;
                        err_timeout_reg <= 1'b1;
                    end
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_op_sequencer.sv
// Directed bench for pe_op_sequencer: a table of commands with hand-computed
// expectations, a tiny PE model returning t_last LATENCY cycles after pe_last,
// plus hand-written power-on and mid-stream reset sequences.

module tb_pe_op_sequencer;

    localparam int LATENCY = 16;
    localparam int CNT_W   = 16;
    localparam int SLACK   = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_vlen;
    logic             cmd_hdr;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [2:0]       pe_op;
    logic             pe_valid;
    logic             pe_last;
    logic             pe_en_itr_sp;
    logic             pe_out_valid;
    logic             pe_out_last;
    logic             busy;
    logic             done;
    logic             err_len;
    logic             err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    pe_op_sequencer #(
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W),
        .SLACK   (SLACK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_vlen     (cmd_vlen),
        .cmd_hdr      (cmd_hdr),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .pe_op        (pe_op),
        .pe_valid     (pe_valid),
        .pe_last      (pe_last),
        .pe_en_itr_sp (pe_en_itr_sp),
        .pe_out_valid (pe_out_valid),
        .pe_out_last  (pe_out_last),
        .busy         (busy),
        .done         (done),
        .err_len      (err_len),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        int vlen;
        int hdr;          // 1: first beat is the VLEN header
        int toggle;       // 1: s_valid alternates 1,0,1,0 while streaming
        int slast_idx;    // data-beat index on which s_last is driven
        int ret;          // 1: PE model returns t_last LATENCY cycles after pe_last
        int exp_beats;    // handshakes including header
        int exp_last_idx; // handshake index carrying pe_last (-1: none)
        int exp_en_first; // handshake index carrying pe_en_itr_sp (-1: none)
        int exp_en_cnt;
        int exp_done_lat; // cycles from last handshake (or accept) to done
        int exp_err_len;  // sticky value after the command
        int exp_err_tmo;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        cmd_valid    = 1'b0;
        cmd_op       = 3'b000;
        cmd_vlen     = '0;
        cmd_hdr      = 1'b0;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        pe_out_valid = 1'b0;
        pe_out_last  = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  acc_cyc   = 0;
        int  ref_cyc   = 0;
        int  done_cyc  = 0;
        int  ret_at    = -1;
        int  beats     = 0;
        int  last_idx  = -1;
        int  last_cnt  = 0;
        int  en_first  = -1;
        int  en_cnt    = 0;
        int  total     = v.vlen + v.hdr;
        bit  accepted  = 1'b0;
        bit  got_done  = 1'b0;
        bit  first_rdy = 1'b0;
        bit  bad_strm  = 1'b0;
        bit  bad_busy  = 1'b0;
        bit  bad_op    = 1'b0;
        bit  streaming;
        for (int cyc = 0; cyc < 150 && !got_done; cyc++) begin
            @(negedge clk);
            streaming = accepted && (beats < total);
            cmd_valid = !accepted;
            cmd_op    = v.op;
            // After accept the command bus carries junk that must be ignored.
            cmd_vlen  = accepted ? CNT_W'(16'hBEEF) : CNT_W'(v.vlen);
            cmd_hdr   = accepted ? (v.hdr == 0) : (v.hdr != 0);
            // Outside the stream s_valid is held high to probe the gating.
            s_valid   = accepted && (!streaming || v.toggle == 0 || ((cyc - acc_cyc - 1) % 2 == 0));
            s_last    = streaming && s_valid && (beats - v.hdr == v.slast_idx);
            pe_out_valid = (cyc == ret_at);
            pe_out_last  = (cyc == ret_at);
            #1;
            if (!accepted) begin
                if (cyc == 0) first_rdy = cmd_ready;
                if (cmd_ready) begin
                    accepted = 1'b1;
                    acc_cyc  = cyc;
                    ref_cyc  = cyc;
                end
            end else begin
                if (done) begin
                    got_done = 1'b1;
                    done_cyc = cyc;
                end else if (cmd_ready || !busy) begin
                    bad_busy = 1'b1;
                end
                if (pe_op !== v.op) bad_op = 1'b1;
                if (streaming) begin
                    if (s_ready !== 1'b1 || pe_valid !== s_valid) bad_strm = 1'b1;
                end else if (s_ready !== 1'b0 || pe_valid !== 1'b0) begin
                    bad_strm = 1'b1;
                end
                if (pe_last) begin
                    last_cnt++;
                    last_idx = beats;
                end
                if (s_valid && s_ready) begin
                    if (pe_en_itr_sp) begin
                        en_cnt++;
                        if (en_first < 0) en_first = beats;
                    end
                    if (pe_last && v.ret != 0) ret_at = cyc + LATENCY;
                    beats++;
                    ref_cyc = cyc;
                end
            end
        end
        chk($sformatf("v%0d cmd_ready_idle", idx), first_rdy, 1);
        chk($sformatf("v%0d done_seen", idx), got_done, 1);
        chk($sformatf("v%0d beats", idx), beats, v.exp_beats);
        chk($sformatf("v%0d pe_last_idx", idx), last_idx, v.exp_last_idx);
        chk($sformatf("v%0d pe_last_cnt", idx), last_cnt, (v.exp_last_idx >= 0) ? 1 : 0);
        chk($sformatf("v%0d en_itr_first", idx), en_first, v.exp_en_first);
        chk($sformatf("v%0d en_itr_cnt", idx), en_cnt, v.exp_en_cnt);
        chk($sformatf("v%0d stream_gating", idx), bad_strm, 0);
        chk($sformatf("v%0d busy_noready", idx), bad_busy, 0);
        chk($sformatf("v%0d pe_op_hold", idx), bad_op, 0);
        chk($sformatf("v%0d done_latency", idx), got_done ? (done_cyc - ref_cyc) : -1, v.exp_done_lat);
        @(negedge clk);
        drive_idle();
        #1;
        chk($sformatf("v%0d done_single", idx), done, 0);
        chk($sformatf("v%0d idle_busy", idx), busy, 0);
        chk($sformatf("v%0d idle_ready", idx), cmd_ready, 1);
        chk($sformatf("v%0d idle_pe_op", idx), pe_op, v.op);
        chk($sformatf("v%0d err_len", idx), err_len, v.exp_err_len);
        chk($sformatf("v%0d err_timeout", idx), err_timeout, v.exp_err_tmo);
        $display("vec %0d op=%0d vlen=%0d hdr=%0d beats=%0d last_idx=%0d done_lat=%0d err_len=%0d err_tmo=%0d",
                 idx, v.op, v.vlen, v.hdr, beats, last_idx, got_done ? (done_cyc - ref_cyc) : -1,
                 err_len, err_timeout);
    endtask

    initial begin
        //           op      vlen hdr tog slast ret beats last enf enc lat el et
        vecs[0] = '{3'b000, 4,   0,  0,  3,    1,  4,    3,   -1, 0,  17, 0, 0}; // ADD
        vecs[1] = '{3'b001, 3,   1,  0,  2,    1,  4,    3,   0,  1,  17, 0, 0}; // ACC + header
        vecs[2] = '{3'b010, 5,   0,  1,  4,    1,  5,    4,   -1, 0,  17, 0, 0}; // MUL toggling
        vecs[3] = '{3'b100, 2,   0,  0,  1,    1,  2,    1,   -1, 0,  17, 0, 0}; // NOP passthrough
        vecs[4] = '{3'b000, 0,   0,  0,  -1,   0,  0,    -1,  -1, 0,  1,  0, 0}; // empty command
        vecs[5] = '{3'b011, 4,   0,  0,  1,    1,  4,    3,   -1, 0,  17, 1, 0}; // MACC early s_last
        vecs[6] = '{3'b010, 2,   0,  0,  1,    0,  2,    1,   -1, 0,  25, 1, 1}; // MUL timeout
        vecs[7] = '{3'b000, 1,   0,  0,  0,    1,  1,    0,   -1, 0,  17, 1, 1}; // after timeout
        vecs[8] = '{3'b000, 1,   0,  0,  0,    1,  1,    0,   -1, 0,  17, 0, 0}; // after reset

        drive_idle();
        rst_n = 1'b0;

        // Power-on reset: outputs held low, then idle state with NOP opcode.
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1;
        s_valid   = 1'b1;
        #1;
        chk("por_outputs_low", {cmd_ready, s_ready, pe_valid, pe_last, pe_en_itr_sp, busy}, 0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        chk("por_pe_op", pe_op, 3'b100);
        chk("por_busy", busy, 0);
        chk("por_done", done, 0);
        chk("por_errs", {err_len, err_timeout}, 0);
        chk("por_ready", cmd_ready, 1);
        $display("reset released pe_op=%0d busy=%0d cmd_ready=%0d", pe_op, busy, cmd_ready);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Mid-stream reset: ADD vlen=6, reset while beat 2 is offered.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'b000;
        cmd_vlen  = CNT_W'(6);
        cmd_hdr   = 1'b0;
        #1;
        chk("mrst_accept", cmd_ready, 1);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            s_valid   = 1'b1;
            #1;
            chk($sformatf("mrst_beat%0d_ready", b), {s_ready, pe_valid}, 2'b11);
        end
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        #1;
        chk("mrst_outputs_low", {cmd_ready, s_ready, pe_valid, pe_last, pe_en_itr_sp, busy}, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_pe_op", pe_op, 3'b100);
        chk("mrst_done", done, 0);
        chk("mrst_errs", {err_len, err_timeout}, 0);
        @(negedge clk);
        #1;
        chk("mrst_no_done", done, 0);
        $display("mid-stream reset pe_op=%0d busy=%0d done=%0d err_len=%0d err_tmo=%0d",
                 pe_op, busy, done, err_len, err_timeout);

        run_vec(8, vecs[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
